// File: rtl/x_uart_pkg.sv
// Shared UART definitions for x_uart_tx and the future x_uart_rx.
package x_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/x_baud_cnt.sv
// Baud divider: counts 0..CLKS_PER_BIT-1, wraps on its own, ticks on the last count.
module x_baud_cnt
  import x_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/x_uart_tx.sv
// UART transmitter, 8N1 by default; define X_UART_TX_PARITY_EN for an even parity bit.
// Handshake: o_accept is high only in IDLE while i_valid is high; the byte is captured on that edge.
module x_uart_tx
  import x_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic       o_tx,
  output logic       o_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       tick;
  logic       cnt_clr;
  logic       cnt_en;
`ifdef X_UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  assign cnt_en  = (state_q != IDLE);
  assign cnt_clr = (state_q == IDLE) || (state_d != state_q);

  x_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (cnt_clr),
    .i_en  (cnt_en),
    .o_tick(tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    accept  = 1'b0;
`ifdef X_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // Reset dominates: no byte is consumed on a reset edge.
        if (i_valid && !i_rst) begin
          accept  = 1'b1;
          shift_d = i_data;
          bit_d   = 3'd0;
          state_d = START;
`ifdef X_UART_TX_PARITY_EN
          par_d   = ^i_data;
`endif
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
`ifdef X_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef X_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is derived from the next state so o_tx changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START: tx_d = 1'b0;
      DATA:  tx_d = shift_d[0];
`ifdef X_UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef X_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef X_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_accept = accept;
  assign o_tx     = tx_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_x_uart_tx.sv
// Self-checking bench for x_uart_tx with CLKS_PER_BIT=4; honours X_UART_TX_PARITY_EN.
module tb_x_uart_tx;
  import x_uart_pkg::*;

  localparam int CPB = 4;
`ifdef X_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FC = CPB * FRAME_BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       accept;
  logic       tx;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  x_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_data  (data),
    .o_accept(accept),
    .o_tx    (tx),
    .o_busy  (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected line level k cycles after the frame's first edge, built from the frame layout.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef X_UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_accept", 32'(accept), 32'd0);
    end
  endtask

  task automatic offer(input logic [7:0] d);
    @(posedge clk);
    #1;
    valid = 1'b1;
    data  = d;
    exp_q.push_back(d);
  endtask

  task automatic wait_accept(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (accept === 1'b1) got = 1'b1;
      chk("pre_accept_tx", 32'(tx), 32'd1);
      chk("pre_accept_busy", 32'(busy), 32'd0);
    end
    chk("accept_seen", 32'(got), 32'd1);
  endtask

  // Called at the negedge of the accept cycle; walks the whole frame cycle by cycle.
  task automatic check_frame(input logic mid_apply, input logic mid_valid,
                             input logic [7:0] mid_data, input int abort_at);
    logic [7:0] e;
    logic [7:0] dec;
    int slot;
    e   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    dec = 8'h00;
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      chk("frame_tx", 32'(tx), 32'(exp_line(e, k)));
      chk("frame_busy", 32'(busy), 32'd1);
      chk("frame_accept", 32'(accept), 32'd0);
      slot = k / CPB;
      if (slot >= 1 && slot <= 8 && (k % CPB) == CPB / 2) dec[slot-1] = tx;
      if (k == 0 && mid_apply) begin
        valid = mid_valid;
        data  = mid_data;
      end
      if (k == abort_at) begin
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state_idle", 32'(dut.state_q == IDLE), 32'd1);
        chk("rst_accept", 32'(accept), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
    end
    chk("frame_byte", 32'(dec), 32'(e));
  endtask

  initial begin
    int gap;
    logic [7:0] d;
    rst   = 1'b1;
    valid = 1'b0;
    data  = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_accept", 32'(accept), 32'd0);
    chk("reset_state_idle", 32'(dut.state_q == IDLE), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_check(50);

    // single frame 0xA5
    offer(8'hA5);
    wait_accept(3);
    check_frame(1'b0, 1'b0, 8'h00, -1);
    valid = 1'b0;
    idle_check(3);

    // back-to-back 0x00 then 0x41 with i_valid held: accepts 41 clk apart
    offer(8'h00);
    exp_q.push_back(8'h41);
    wait_accept(3);
    check_frame(1'b1, 1'b1, 8'h41, -1);
    wait_accept(1);
    check_frame(1'b0, 1'b0, 8'h00, -1);
    valid = 1'b0;
    idle_check(3);

    // 0xFF with data changed and valid dropped mid-frame
    offer(8'hFF);
    wait_accept(3);
    check_frame(1'b1, 1'b0, 8'h00, -1);
    idle_check(2 * FC);

    // reset during data bit 3 of 0x3C, then a clean frame 0x5A
    offer(8'h3C);
    wait_accept(3);
    check_frame(1'b1, 1'b0, 8'h3C, 4 * CPB + 1);
    exp_q.push_back(8'h5A);
    wait_accept(1);
    check_frame(1'b0, 1'b0, 8'h00, -1);
    valid = 1'b0;
    idle_check(3);

    // 0x07 then 0x03 back-to-back (odd then even bit count)
    offer(8'h07);
    exp_q.push_back(8'h03);
    wait_accept(3);
    check_frame(1'b1, 1'b1, 8'h03, -1);
    wait_accept(1);
    check_frame(1'b0, 1'b0, 8'h00, -1);
    valid = 1'b0;
    idle_check(2);

    // randomized bytes, gaps and mid-frame input disturbance
    for (int n = 0; n < 24; n++) begin
      gap = int'($urandom_range(0, 3));
      d   = 8'($urandom_range(0, 255));
      if (gap > 0) begin
        valid = 1'b0;
        idle_check(gap);
      end
      offer(d);
      wait_accept(1);
      check_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), -1);
    end
    valid = 1'b0;
    idle_check(3);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
